tile_scheduler: RTL
===================

Name: tile_scheduler

Overview:
- Sequences the tile-divider datapath for one SIZE x SIZE image frame.
- Pulses the divider's capture strobe, then waits one cycle for its registered tile array to settle.
- Issues the (SIZE/FILTER_SIZE)^2 tiles in raster order to the downstream convolution engine over a valid/ready handshake.
- Limits tiles in flight with a credit counter, and reports frame completion once every tile result has returned.

Parameters:
- SIZE, 9, image edge length in pixels; must be a multiple of FILTER_SIZE.
- FILTER_SIZE, 3, tile/filter edge length.
- MAX_OUT, 2, max tiles issued but not yet answered by result_valid; range 1..NT.
- Derived: T=SIZE/FILTER_SIZE, NT=T*T, IW=max(1,$clog2(NT)), AW=max(1,$clog2(SIZE)), CW=$clog2(MAX_OUT+1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  begin a frame; sampled only in IDLE
- abort  in  1  cancel the current frame
- img_snap  out  1  one-cycle strobe telling the divider to capture the image array
- tile_valid  out  1  tile_idx/row_base/col_base are valid
- tile_ready  in  1  downstream accepts the tile
- tile_idx  out  IW  tile index, 0..NT-1
- row_base  out  AW  first image row of the tile
- col_base  out  AW  first image column of the tile
- result_valid  in  1  one pulse per finished tile from the engine
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at frame completion
- err  out  1  sticky flag: result_valid arrived with zero tiles outstanding

Behaviour:
- Reset (async, while rst=1): state=IDLE; all outputs 0; tile counter, row/col counters and credit counter = 0. err is cleared only by rst.
- States: IDLE, SNAP, SETTLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 -> SNAP. Start is ignored in every other state.
- SNAP: img_snap=1 for exactly this cycle -> SETTLE.
- SETTLE: one cycle, covering the divider's one-register latency -> ISSUE.
- ISSUE:
  - tile_valid=1 iff outstanding<MAX_OUT.
  - Handshake = tile_valid & tile_ready.
  - On handshake: tile_idx increments; col_base += FILTER_SIZE; when col_base wraps past the last tile column, col_base=0 and row_base += FILTER_SIZE.
  - Tile i always presents row_base=(i/T)*FILTER_SIZE and col_base=(i%T)*FILTER_SIZE. Use counters, not dividers.
  - Handshake on tile NT-1 -> DRAIN.
- While tile_valid=1 and tile_ready=0, tile_idx, row_base and col_base are held stable.
- Credit counter:
  - +1 on handshake; -1 on result_valid when outstanding>0.
  - Both in the same cycle -> unchanged.
  - result_valid with outstanding=0 -> counter unchanged, err<=1.
- DRAIN: tile_valid=0; when outstanding=0 (including outstanding reaching 0 this cycle) -> DONE.
- DONE: done=1 for one cycle -> IDLE. busy is still 1 in DONE.
- abort:
  - In any non-IDLE state, abort -> IDLE on the next edge.
  - Outputs and counters are cleared as at reset, except err, which is kept.
  - No done pulse. A handshake in the abort cycle is discarded.
  - Abort has priority over all other transitions.
- After abort, result_valid pulses from the engine raise err if they arrive with outstanding=0.
- Latency, start to first tile_valid: 3 cycles (start sampled at edge 0; SNAP, SETTLE, tile_valid high in the third cycle).
- Minimum frame time with tile_ready=1 and instant results: 3 + NT + 1 cycles.

Test Plan:
- Defaults, tile_ready=1, result_valid one cycle after each handshake -> img_snap once; 9 tiles issued, idx 0..8; (row,col) = (0,0),(0,3),(0,6),(3,0)...(6,6); single done pulse; err=0.
- tile_ready low for 5 cycles at tile 4 -> tile_valid stays high with idx=4, row=3, col=3 held stable; resumes when ready; 9 tiles total.
- MAX_OUT=2, no results returned -> exactly 2 handshakes, then tile_valid=0. One result_valid -> one more tile. After tile 8, DRAIN holds until outstanding=0, then done.
- Simultaneous handshake and result_valid with outstanding=1 -> outstanding stays 1, checked every cycle.
- abort during tile 5 and rst asserted mid-DRAIN -> next cycle IDLE, busy=0, tile_valid=0, no done. A new start replays from tile 0 with a fresh img_snap.
- result_valid with outstanding=0 in IDLE -> err=1 stays set through a following full frame; cleared only by rst.

Source files
------------

// File: rtl/tile_scheduler.sv
// rtl/tile_scheduler.sv - frame sequencer for the tile divider: snap, settle, raster tile issue, credit-limited drain
module tile_scheduler #(
  parameter int SIZE        = 9,
  parameter int FILTER_SIZE = 3,
  parameter int MAX_OUT     = 2,
  localparam int T          = SIZE / FILTER_SIZE,
  localparam int NT         = T * T,
  localparam int IW         = (NT > 1) ? $clog2(NT) : 1,
  localparam int AW         = (SIZE > 1) ? $clog2(SIZE) : 1,
  localparam int CW         = $clog2(MAX_OUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          img_snap,
  output logic          tile_valid,
  input  logic          tile_ready,
  output logic [IW-1:0] tile_idx,
  output logic [AW-1:0] row_base,
  output logic [AW-1:0] col_base,
  input  logic          result_valid,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNAP,
    S_SETTLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] outstanding, outstanding_nxt;
  logic          handshake;
  logic          result_ok;
  logic          last_tile;
  logic          col_last;
  logic          kill;

  // Credit gate: the engine never holds more than MAX_OUT unanswered tiles.
  assign tile_valid = (state == S_ISSUE) && (outstanding < CW'(MAX_OUT));
  assign kill       = abort && (state != S_IDLE);
  assign handshake  = tile_valid && tile_ready && !kill;
  assign result_ok  = result_valid && (outstanding != '0);
  assign last_tile  = (tile_idx == IW'(NT - 1));
  assign col_last   = (col_base == AW'(SIZE - FILTER_SIZE));

  always_comb begin
    outstanding_nxt = outstanding;
    case ({handshake, result_ok})
      2'b10:   outstanding_nxt = outstanding + CW'(1);
      2'b01:   outstanding_nxt = outstanding - CW'(1);
      default: outstanding_nxt = outstanding;
    endcase
  end

  always_comb begin
    state_nxt = state;
    img_snap  = 1'b0;
    done      = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE:   if (start) state_nxt = S_SNAP;
      S_SNAP: begin
        img_snap  = 1'b1;
        state_nxt = S_SETTLE;
      end
      S_SETTLE: state_nxt = S_ISSUE;
      S_ISSUE:  if (handshake && last_tile) state_nxt = S_DRAIN;
      S_DRAIN:  if (outstanding_nxt == '0) state_nxt = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
    if (kill) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Position counters step in raster order; no division needed for the bases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      tile_idx    <= '0;
      row_base    <= '0;
      col_base    <= '0;
    end else if (kill) begin
      outstanding <= '0;
      tile_idx    <= '0;
      row_base    <= '0;
      col_base    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (state == S_IDLE && start) begin
        tile_idx <= '0;
        row_base <= '0;
        col_base <= '0;
      end else if (handshake) begin
        if (last_tile) begin
          tile_idx <= '0;
          row_base <= '0;
          col_base <= '0;
        end else begin
          tile_idx <= tile_idx + IW'(1);
          if (col_last) begin
            col_base <= '0;
            row_base <= row_base + AW'(FILTER_SIZE);
          end else begin
            col_base <= col_base + AW'(FILTER_SIZE);
          end
        end
      end
    end
  end

  // Sticky protocol error: a result with nothing outstanding; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (result_valid && outstanding == '0) begin
      err <= 1'b1;
    end
  end

endmodule
